ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite responder holding a word-organised register-file memory, the subordinate end of the bus interface the manager-side bench and properties drive. It decodes address-phase signals, inserts a configurable number of wait states, performs byte/halfword/word reads and writes on little-endian byte lanes, and returns a two-cycle ERROR response for illegal transfers. It sits behind the interconnect decoder (HSEL) and the HREADY mux, and is the DUT target for the AHB formal and simulation environments.

## Interface

- ADDR_W, 32, HADDR width
- DATA_W, 32, HWDATA/HRDATA width; fixed at 32 for this block
- DEPTH, 256, memory words; power of two, ≥ 4
- WAIT_STATES, 0, wait cycles inserted per OKAY transfer (0–15)

- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  synchronous, active-low reset
- HSEL  in  1  slave select from decoder
- HADDR  in  ADDR_W  transfer address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half, 2 = word
- HBURST  in  3  accepted, no effect on behaviour
- HWDATA  in  DATA_W  write data, valid in data phase
- HREADY  in  1  bus-level ready (mux output)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_W  read data

## Operation

- Transfer accepted at a rising edge when HSEL & HREADY & HTRANS[1]. Address, HWRITE, HSIZE are registered for the data phase.
- IDLE/BUSY, or HSEL=0, with HREADY=1: nothing is registered; zero-wait OKAY data phase.
- Illegal transfer, errored: HSIZE > 2; address misaligned to HSIZE (half with HADDR[0]=1, word with HADDR[1:0]≠0); HADDR ≥ 4*DEPTH.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0, counter decrements.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - Accepted legal transfer with WAIT_STATES>0 → WAIT, counter=WAIT_STATES-1. Leaves WAIT when counter=0 and that cycle ends; the next state depends on any new transfer accepted on the final ready edge.
  - Accepted legal transfer with WAIT_STATES=0 → IDLE (data phase completes next cycle).
  - Accepted illegal transfer → ERR1 (no wait states), then ERR2 unconditionally. ERR2 may accept a new address phase like IDLE.
- Write: commits on the data-phase cycle where HREADYOUT=1, for OKAY transfers only. Only lanes selected by registered HADDR[1:0]/HSIZE are updated; byte k uses HWDATA[8k+7:8k]. Errored writes never modify memory.
- Read: HRDATA loaded at the accepting edge from mem[HADDR word index], then held through wait states and until the next accepted read. The full word is returned; the master selects the lanes.
- Read-after-write bypass: if a read is accepted on the same edge a write commits to the same word, HRDATA gets the post-write word (byte-lane merge).
- Errored read: HRDATA is not updated.

## Timing

- Reset (HRESETn=0 at a rising edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, counter=0, registered address phase cleared to "no transfer". Memory contents are not reset.
- Reset mid-transfer aborts it: a pending write is not committed, and the next cycle is IDLE/OKAY.
- OKAY latency: data phase is WAIT_STATES+1 cycles; HREADYOUT is low for the first WAIT_STATES cycles.
- ERROR: exactly 2 data-phase cycles: (HREADYOUT=0, HRESP=1) then (1, 1).
- Back-to-back pipelined transfers at WAIT_STATES=0 sustain one transfer per cycle.
- HRESP=1 never appears with HREADYOUT=1 unless the previous cycle was ERR1.
- HREADY=0 from another slave: no address sampled; outputs are held in IDLE.

## Test plan

- Reset → HREADYOUT=1, HRESP=0, HRDATA=0x0. Reassert reset during WAIT with WAIT_STATES=3 → next cycle IDLE, and a pending write to 0x10 is not committed.
- WAIT_STATES=0: word write 0xDEADBEEF @0x04, then read @0x04 back-to-back → HRDATA=0xDEADBEEF in the read data phase via bypass, and one transfer per cycle.
- Byte write 0xAA @0x05 over word 0x11223344 @0x04, then read → 0x1122AA44. Half write 0xBEEF @0x06 → 0xBEEFAA44.
- WAIT_STATES=2: read @0x08 → HREADYOUT low for 2 cycles, data valid on the 3rd cycle, HRESP=0 throughout.
- Misaligned word write @0x02, HSIZE=3, and address 4*DEPTH → each gives ERR1 (0,1) then ERR2 (1,1), and memory is unchanged.
- HSEL=0, or HTRANS=BUSY/IDLE, with HREADY=1 → HREADYOUT=1, HRESP=0, no memory or HRDATA change.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate backed by a word-organised memory: little-endian byte/half/word
// access, a configurable number of wait states and a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              hreadyout_q;
  logic              hresp_q;
  logic [DATA_W-1:0] hrdata_q;

  // Registered data phase of the last accepted legal transfer.
  logic              dp_valid;
  logic              dp_write;
  logic [IDX_W-1:0]  dp_idx;
  logic [3:0]        dp_strb;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic              illegal;
  logic              commit;
  logic [IDX_W-1:0]  a_idx;
  logic [3:0]        a_strb;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_word;
  logic              unused_burst;

  assign unused_burst = ^HBURST;

  assign accept       = ((state == ST_IDLE) || (state == ST_ERR2)) && HSEL && HREADY && HTRANS[1];
  assign misaligned   = ((HSIZE == 3'd1) && HADDR[0]) || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign out_of_range = (HADDR >> (IDX_W + 2)) != '0;
  assign illegal      = (HSIZE > 3'd2) || misaligned || out_of_range;
  assign a_idx        = HADDR[IDX_W+1:2];

  // A write retires on the ready cycle of its data phase; reset aborts it.
  assign commit = HRESETn && (state == ST_IDLE) && dp_valid && dp_write;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_strb = 4'b0000;
    case (HSIZE)
      3'd0:    a_strb = 4'b0001 << HADDR[1:0];
      3'd1:    a_strb = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    a_strb = 4'b1111;
      default: a_strb = 4'b0000;
    endcase
  end

  always_comb begin
    merged = mem[dp_idx];
    for (int k = 0; k < 4; k++) begin
      if (dp_strb[k]) merged[8*k +: 8] = HWDATA[8*k +: 8];
    end
  end

  // A read accepted on the edge that retires a write to the same word sees the new data.
  assign rd_word = (commit && (dp_idx == a_idx)) ? merged : mem[a_idx];

  // NOTE: the array carries no reset so it maps onto plain storage; only control is reset.
  always_ff @(posedge HCLK) begin
    if (commit) mem[dp_idx] <= merged;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      dp_valid    <= 1'b0;
      dp_write    <= 1'b0;
      dp_idx      <= '0;
      dp_strb     <= 4'b0000;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          dp_valid <= accept && !illegal;
          if (accept) begin
            dp_write <= HWRITE;
            dp_idx   <= a_idx;
            dp_strb  <= a_strb;
          end
          if (accept && illegal) begin
            state       <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else if (accept && (WAIT_STATES > 0)) begin
            state       <= ST_WAIT;
            wait_cnt    <= 4'(WAIT_STATES - 1);
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b0;
          end else begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
          if (accept && !illegal && !HWRITE) hrdata_q <= rd_word;
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances (0, 2 and 3 wait states) driven by a
// pipelined master model, checked against a byte-addressed reference memory.
module tb_ahb_sram_slave;

  localparam logic [1:0] TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;
  localparam int N_INST = 3;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic                   clk;
  logic                   hresetn;
  logic [N_INST-1:0]      hsel;
  logic [N_INST-1:0][31:0] haddr;
  logic [N_INST-1:0][1:0] htrans;
  logic [N_INST-1:0]      hwrite;
  logic [N_INST-1:0][2:0] hsize;
  logic [N_INST-1:0][2:0] hburst;
  logic [N_INST-1:0][31:0] hwdata;
  logic [N_INST-1:0]      hready;
  logic [N_INST-1:0]      hready_block;
  logic [N_INST-1:0]      hreadyout;
  logic [N_INST-1:0]      hresp;
  logic [N_INST-1:0][31:0] hrdata;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          cur = 0;
  logic [31:0] pend_wdata = 32'h0;
  exp_t        exp_q[$];
  logic [7:0]  mdl [N_INST][1024];
  logic [31:0] last_rd [N_INST];
  bit          mon_in_dp = 0;
  int          mon_lows = 0;

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    assign hready[g] = hreadyout[g] & ~hready_block[g];
    ahb_sram_slave #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(256),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[g]), .HADDR(haddr[g]), .HTRANS(htrans[g]),
      .HWRITE(hwrite[g]), .HSIZE(hsize[g]), .HBURST(hburst[g]), .HWDATA(hwdata[g]),
      .HREADY(hready[g]), .HREADYOUT(hreadyout[g]), .HRESP(hresp[g]), .HRDATA(hrdata[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s (inst %0d): got 0x%08h, required 0x%08h", name, cur, act, expv);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic bit is_illegal(input logic [2:0] sz, input logic [31:0] addr);
    return (sz > 3'd2) || (sz == 3'd1 && addr[0]) || (sz == 3'd2 && addr[1:0] != 2'b00) ||
           (addr >= 32'd1024);
  endfunction

  function automatic logic [31:0] mdl_word(input int d, input logic [31:0] addr);
    int b;
    b = int'({addr[31:2], 2'b00});
    return {mdl[d][b+3], mdl[d][b+2], mdl[d][b+1], mdl[d][b]};
  endfunction

  task automatic mdl_write(input int d, input logic [2:0] sz, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int a;
    a = int'(addr);
    for (int i = 0; i < (1 << sz); i++) mdl[d][a+i] = wdata[8*((a+i)%4) +: 8];
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (!hready[d] && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!hready[d]) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout (inst %0d): HREADY low for %0d cycles, required high", d, n);
    end
    @(posedge clk);
    #1;
  endtask

  // One address phase; the previous transfer's write data rides along on HWDATA.
  task automatic xfer(input int d, input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit upd = 1'b1);
    exp_t e;
    hsel[d]   = sel;
    htrans[d] = trans;
    hwrite[d] = wr;
    hsize[d]  = sz;
    haddr[d]  = addr;
    hburst[d] = 3'($urandom);
    hwdata[d] = pend_wdata;
    wait_ready(d);
    if (sel && trans[1]) begin
      e.err   = is_illegal(sz, addr);
      e.waits = e.err ? 1 : ws_of(d);
      if (!e.err && upd) begin
        if (wr) mdl_write(d, sz, addr, wdata);
        else    last_rd[d] = mdl_word(d, addr);
      end
      e.rdata = last_rd[d];
      exp_q.push_back(e);
    end
    pend_wdata = wdata;
  endtask

  task automatic drain(input int d);
    xfer(d, 1'b0, TR_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
    xfer(d, 1'b0, TR_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic rand_traffic(input int d, input int n);
    int          r;
    logic [2:0]  sz;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      r  = $urandom_range(0, 99);
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 127));
      a  = a & ~((32'd1 << sz) - 32'd1);
      if (r < 70) begin
        xfer(d, 1'b1, {1'b1, 1'($urandom)}, 1'($urandom), sz, a, $urandom);
      end else if (r < 85) begin
        case ($urandom_range(0, 2))
          0:       xfer(d, 1'b1, TR_NONSEQ, 1'($urandom), 3'($urandom_range(1, 2)), a | 32'd1, $urandom);
          1:       xfer(d, 1'b1, TR_NONSEQ, 1'($urandom), 3'($urandom_range(3, 7)), a, $urandom);
          default: xfer(d, 1'b1, TR_NONSEQ, 1'($urandom), 3'd2, 32'd1024 + (a & ~32'd3), $urandom);
        endcase
      end else if (r < 93) begin
        xfer(d, 1'b0, {1'b1, 1'($urandom)}, 1'($urandom), sz, a, $urandom);
      end else begin
        xfer(d, 1'b1, {1'b0, 1'($urandom)}, 1'($urandom), sz, a, $urandom);
      end
    end
  endtask

  // Monitor: pops one expectation per completed data phase, checks idle cycles otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!hresetn) begin
        mon_in_dp = 0;
        mon_lows  = 0;
      end else begin
        if (mon_in_dp) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_dphase (inst %0d): data phase with no expected transfer", cur);
            mon_in_dp = 0;
          end else if (!hreadyout[cur]) begin
            e = exp_q[0];
            mon_lows++;
            check("resp_in_wait", 32'(hresp[cur]), 32'(e.err));
          end else begin
            e = exp_q.pop_front();
            check("wait_cycles", 32'(mon_lows), 32'(e.waits));
            check("resp_final", 32'(hresp[cur]), 32'(e.err));
            check("rdata", hrdata[cur], e.rdata);
            mon_in_dp = 0;
          end
        end else begin
          check("idle_ready", 32'(hreadyout[cur]), 32'd1);
          check("idle_resp", 32'(hresp[cur]), 32'd0);
        end
        if (hsel[cur] && hready[cur] && htrans[cur][1]) begin
          mon_in_dp = 1;
          mon_lows  = 0;
        end
      end
    end
  end

  initial begin
    int c0;
    hresetn      = 1'b0;
    hsel         = '0;
    haddr        = '0;
    htrans       = '0;
    hwrite       = '0;
    hsize        = '0;
    hburst       = '0;
    hwdata       = '0;
    hready_block = '0;
    for (int d = 0; d < N_INST; d++) last_rd[d] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < N_INST; d++) begin
      cur = d;
      check("reset_hreadyout", 32'(hreadyout[d]), 32'd1);
      check("reset_hresp", 32'(hresp[d]), 32'd0);
      check("reset_hrdata", hrdata[d], 32'h0);
    end
    hresetn = 1'b1;

    // Give every instance a known image of words 0..31.
    for (int d = 0; d < N_INST; d++) begin
      cur = d;
      for (int w = 0; w < 32; w++) xfer(d, 1'b1, TR_NONSEQ, 1'b1, 3'd2, 32'(w * 4), $urandom);
      drain(d);
    end

    // Zero-wait instance: bypass, lane merges, throughput, errors, no-transfer cycles.
    cur = 0;
    xfer(0, 1'b1, TR_NONSEQ, 1'b1, 3'd2, 32'h04, 32'hDEADBEEF);
    xfer(0, 1'b1, TR_NONSEQ, 1'b0, 3'd2, 32'h04, $urandom);
    check("bypass_read", hrdata[0], 32'hDEADBEEF);
    xfer(0, 1'b1, TR_NONSEQ, 1'b1, 3'd2, 32'h04, 32'h11223344);
    xfer(0, 1'b1, TR_NONSEQ, 1'b1, 3'd0, 32'h05, 32'hAAAAAAAA);
    xfer(0, 1'b1, TR_NONSEQ, 1'b0, 3'd2, 32'h04, $urandom);
    check("byte_merge", hrdata[0], 32'h1122AA44);
    xfer(0, 1'b1, TR_NONSEQ, 1'b1, 3'd1, 32'h06, 32'hBEEFBEEF);
    xfer(0, 1'b1, TR_NONSEQ, 1'b0, 3'd2, 32'h04, $urandom);
    check("half_merge", hrdata[0], 32'hBEEFAA44);

    c0 = cyc;
    for (int k = 0; k < 8; k++) xfer(0, 1'b1, TR_SEQ, 1'(k % 2), 3'd2, 32'(8 * k), $urandom);
    check("throughput_cycles", 32'(cyc - c0), 32'd8);

    xfer(0, 1'b1, TR_NONSEQ, 1'b0, 3'd2, 32'h00, $urandom);
    xfer(0, 1'b1, TR_NONSEQ, 1'b1, 3'd2, 32'h02, 32'h5A5A5A5A);
    xfer(0, 1'b1, TR_NONSEQ, 1'b1, 3'd3, 32'h00, 32'h5A5A5A5A);
    xfer(0, 1'b1, TR_NONSEQ, 1'b1, 3'd2, 32'd1024, 32'h5A5A5A5A);
    xfer(0, 1'b1, TR_NONSEQ, 1'b0, 3'd1, 32'h01, $urandom);
    xfer(0, 1'b1, TR_NONSEQ, 1'b0, 3'd2, 32'h00, $urandom);
    xfer(0, 1'b0, TR_NONSEQ, 1'b1, 3'd2, 32'h00, 32'h77777777);
    xfer(0, 1'b1, TR_BUSY, 1'b1, 3'd2, 32'h00, 32'h77777777);
    xfer(0, 1'b1, TR_IDLE, 1'b1, 3'd2, 32'h00, 32'h77777777);
    check("hrdata_hold", hrdata[0], last_rd[0]);
    xfer(0, 1'b1, TR_NONSEQ, 1'b0, 3'd2, 32'h00, $urandom);
    drain(0);

    // Another slave holds HREADY low: the address phase must be ignored.
    hready_block[0] = 1'b1;
    hsel[0] = 1'b1; htrans[0] = TR_NONSEQ; hwrite[0] = 1'b1; hsize[0] = 3'd2;
    haddr[0] = 32'h08; hwdata[0] = 32'h66666666;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("blocked_ready", 32'(hreadyout[0]), 32'd1);
      check("blocked_resp", 32'(hresp[0]), 32'd0);
    end
    hsel[0] = 1'b0; htrans[0] = TR_IDLE;
    hready_block[0] = 1'b0;
    xfer(0, 1'b1, TR_NONSEQ, 1'b0, 3'd2, 32'h08, $urandom);
    rand_traffic(0, 300);
    drain(0);

    // Two wait states.
    cur = 1;
    xfer(1, 1'b1, TR_NONSEQ, 1'b0, 3'd2, 32'h08, $urandom);
    rand_traffic(1, 80);
    drain(1);

    // Three wait states, with reset asserted in the middle of a write's wait states.
    cur = 2;
    xfer(2, 1'b1, TR_NONSEQ, 1'b1, 3'd2, 32'h10, 32'hCAFEF00D, 1'b0);
    hsel[2] = 1'b0; htrans[2] = TR_IDLE; hwdata[2] = pend_wdata;
    @(posedge clk);
    #1;
    hresetn = 1'b0;
    @(posedge clk);
    #1;
    hresetn = 1'b1;
    exp_q.delete();
    for (int d = 0; d < N_INST; d++) last_rd[d] = 32'h0;
    pend_wdata = 32'h0;
    check("abort_hreadyout", 32'(hreadyout[2]), 32'd1);
    check("abort_hresp", 32'(hresp[2]), 32'd0);
    check("abort_hrdata", hrdata[2], 32'h0);
    xfer(2, 1'b1, TR_NONSEQ, 1'b0, 3'd2, 32'h10, $urandom);
    rand_traffic(2, 60);
    drain(2);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
